// File: rtl/pipe_stage_pkg.sv
// Shared types for the core's pipeline stage registers.
// State encoding, datapath actions, and the per-stage payload bundles.
package pipe_stage_pkg;

    localparam int PIPE_OCC_WIDTH = 2;

    // Canonical RISC-V NOP (addi x0, x0, 0), used as the IF/ID bubble.
    localparam logic [31:0] NOOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } pipe_state_t;

    // What the datapath registers do on the coming clock edge.
    typedef enum logic [2:0] {
        ACT_HOLD      = 3'd0,
        ACT_LOAD_MAIN = 3'd1,
        ACT_LOAD_SKID = 3'd2,
        ACT_PROMOTE   = 3'd3,
        ACT_CLEAR     = 3'd4
    } pipe_act_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_bus_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [3:0]  alu_op;
    } id_ex_bus_t;

endpackage

// File: rtl/pipe_stage_ctrl.sv
// Pipeline stage control: FSM, handshake, datapath action select, occupancy.
// Latency: state and status registered; action select is combinational.
// Backpressure: SKID=1 ready from a register, SKID=0 ready = ~valid | i_ready.
module pipe_stage_ctrl
    import pipe_stage_pkg::*;
#(
    parameter int SKID = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_valid,
    input  logic                      i_ready,
    input  logic                      i_flush,
    output logic                      o_ready,
    output logic                      o_valid,
    output logic [PIPE_OCC_WIDTH-1:0] o_occupancy,
    output pipe_act_t                 act
);

    pipe_state_t               state_q;
    pipe_state_t               state_nxt;
    logic                      valid_q;
    logic                      ready_q;
    logic [PIPE_OCC_WIDTH-1:0] occ_q;
    logic                      up_xfer;
    logic                      dn_xfer;

    assign o_ready     = (SKID != 0) ? ready_q : (~valid_q | i_ready);
    assign o_valid     = valid_q;
    assign o_occupancy = occ_q;

    assign up_xfer = i_valid & o_ready;
    assign dn_xfer = valid_q & i_ready;

    // With SKID=0, BUSY never sees an upstream-only transfer because o_ready
    // is low there, so FULL is unreachable and the same FSM serves both modes.
    always_comb begin
        state_nxt = state_q;
        act       = ACT_HOLD;
        if (i_flush) begin
            state_nxt = EMPTY;
            act       = ACT_CLEAR;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (up_xfer) begin
                        state_nxt = BUSY;
                        act       = ACT_LOAD_MAIN;
                    end
                end
                BUSY: begin
                    if (up_xfer && dn_xfer) begin
                        act = ACT_LOAD_MAIN;
                    end else if (dn_xfer) begin
                        state_nxt = EMPTY;
                        act       = ACT_CLEAR;
                    end else if (up_xfer) begin
                        state_nxt = FULL;
                        act       = ACT_LOAD_SKID;
                    end
                end
                FULL: begin
                    if (dn_xfer) begin
                        state_nxt = BUSY;
                        act       = ACT_PROMOTE;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                    act       = ACT_CLEAR;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            occ_q   <= '0;
        end else begin
            state_q <= state_nxt;
            valid_q <= (state_nxt != EMPTY);
            ready_q <= (state_nxt != FULL);
            case (state_nxt)
                BUSY:    occ_q <= PIPE_OCC_WIDTH'(1);
                FULL:    occ_q <= PIPE_OCC_WIDTH'(2);
                default: occ_q <= '0;
            endcase
        end
    end

endmodule

// File: rtl/pipe_stage.sv
// Reusable pipeline stage register with valid/ready, optional skid entry and flush.
// Latency: one cycle from upstream transfer to o_valid when empty.
// Backpressure: SKID=1 absorbs one in-flight payload; SKID=0 passes i_ready to o_ready.
module pipe_stage
    import pipe_stage_pkg::*;
#(
    parameter int               WIDTH  = 32,
    parameter logic [WIDTH-1:0] BUBBLE = '0,
    parameter int               SKID   = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic [WIDTH-1:0]          i_data,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [WIDTH-1:0]          o_data,
    input  logic                      i_flush,
    output logic [PIPE_OCC_WIDTH-1:0] o_occupancy
);

    pipe_act_t        act;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    pipe_stage_ctrl #(
        .SKID (SKID)
    ) u_ctrl (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (i_valid),
        .i_ready     (i_ready),
        .i_flush     (i_flush),
        .o_ready     (o_ready),
        .o_valid     (o_valid),
        .o_occupancy (o_occupancy),
        .act         (act)
    );

    // The main entry is reloaded with BUBBLE whenever the stage empties, so
    // o_data comes straight from a register and reads BUBBLE while invalid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q <= BUBBLE;
        end else begin
            case (act)
                ACT_LOAD_MAIN: main_q <= i_data;
                ACT_PROMOTE:   main_q <= skid_q;
                ACT_CLEAR:     main_q <= BUBBLE;
                default:       main_q <= main_q;
            endcase
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    skid_q <= BUBBLE;
                end else if (act == ACT_LOAD_SKID) begin
                    skid_q <= i_data;
                end
            end
        end else begin : g_no_skid
            assign skid_q = BUBBLE;
        end
    endgenerate

    assign o_data = main_q;

endmodule

// File: tb/tb_pipe_stage.sv
// Bench for pipe_stage: one SKID=1 and one SKID=0 instance checked every cycle
// against a queue model of a bounded FIFO, directed scenarios then random traffic.
module tb_pipe_stage;

    localparam int          W   = 8;
    localparam logic [W-1:0] BB1 = 8'h5A;
    localparam logic [W-1:0] BB0 = 8'hA5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         v1, r1, f1, or1, ov1;
    logic [W-1:0] d1, od1;
    logic [1:0]   occ1;
    logic         v0, r0, f0, or0, ov0;
    logic [W-1:0] d0, od0;
    logic [1:0]   occ0;

    pipe_stage #(.WIDTH(W), .BUBBLE(BB1), .SKID(1)) dut1 (
        .clk(clk), .rst(rst), .i_valid(v1), .o_ready(or1), .i_data(d1),
        .o_valid(ov1), .i_ready(r1), .o_data(od1), .i_flush(f1), .o_occupancy(occ1)
    );

    pipe_stage #(.WIDTH(W), .BUBBLE(BB0), .SKID(0)) dut0 (
        .clk(clk), .rst(rst), .i_valid(v0), .o_ready(or0), .i_data(d0),
        .o_valid(ov0), .i_ready(r0), .o_data(od0), .i_flush(f0), .o_occupancy(occ0)
    );

    int vectors = 0;
    int miscompares = 0;

    // Model: each stage is a FIFO holding at most 2 (SKID=1) or 1 (SKID=0) entries.
    logic [W-1:0] q1[$];
    logic [W-1:0] q0[$];

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_rdy1();
        return q1.size() < 2;
    endfunction

    function automatic logic exp_rdy0();
        return (q0.size() == 0) || r0;
    endfunction

    task automatic check_all();
        chk_eq("s1_ready", 32'(or1), 32'(exp_rdy1()));
        chk_eq("s1_valid", 32'(ov1), 32'(q1.size() != 0));
        chk_eq("s1_data",  32'(od1), 32'((q1.size() != 0) ? q1[0] : BB1));
        chk_eq("s1_occ",   32'(occ1), q1.size());
        chk_eq("s0_ready", 32'(or0), 32'(exp_rdy0()));
        chk_eq("s0_valid", 32'(ov0), 32'(q0.size() != 0));
        chk_eq("s0_data",  32'(od0), 32'((q0.size() != 0) ? q0[0] : BB0));
        chk_eq("s0_occ",   32'(occ0), q0.size());
    endtask

    // Inputs are set just after a negedge; check, clock, update the model.
    task automatic tick();
        logic up1, dn1, up0, dn0;
        #1;
        check_all();
        up1 = v1 & exp_rdy1();
        dn1 = r1 & (q1.size() != 0);
        up0 = v0 & exp_rdy0();
        dn0 = r0 & (q0.size() != 0);
        @(posedge clk);
        if (rst) begin
            q1.delete();
            q0.delete();
        end else begin
            if (f1) q1.delete();
            else begin
                if (dn1) void'(q1.pop_front());
                if (up1) q1.push_back(d1);
            end
            if (f0) q0.delete();
            else begin
                if (dn0) void'(q0.pop_front());
                if (up0) q0.push_back(d0);
            end
        end
        @(negedge clk);
    endtask

    task automatic drv1(input logic v, input logic [W-1:0] d, input logic r, input logic f);
        v1 = v; d1 = d; r1 = r; f1 = f;
        tick();
    endtask

    task automatic drv0(input logic v, input logic [W-1:0] d, input logic r, input logic f);
        v0 = v; d0 = d; r0 = r; f0 = f;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        v1 = 0; d1 = 0; r1 = 0; f1 = 0;
        v0 = 0; d0 = 0; r0 = 0; f0 = 0;
        #1;
        check_all();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Streaming 1..8 at full rate, then drain.
        for (int i = 1; i <= 8; i++) drv1(1'b1, W'(i), 1'b1, 1'b0);
        drv1(1'b0, '0, 1'b1, 1'b0);
        drv1(1'b0, '0, 1'b1, 1'b0);

        // Backpressure: 0x10, 0x11 fill the stage, 0x12 is held off.
        drv1(1'b1, 8'h10, 1'b0, 1'b0);
        drv1(1'b1, 8'h11, 1'b0, 1'b0);
        drv1(1'b1, 8'h12, 1'b0, 1'b0);
        drv1(1'b1, 8'h12, 1'b1, 1'b0);
        drv1(1'b1, 8'h12, 1'b1, 1'b0);
        repeat (3) drv1(1'b0, '0, 1'b1, 1'b0);

        // Flush while BUSY with a simultaneous upstream handshake.
        drv1(1'b1, 8'h20, 1'b0, 1'b0);
        drv1(1'b1, 8'h21, 1'b0, 1'b1);
        drv1(1'b0, '0, 1'b1, 1'b0);
        drv1(1'b0, '0, 1'b1, 1'b0);

        // Reset mid-stream from FULL, with upstream still offering data.
        drv1(1'b1, 8'h0A, 1'b0, 1'b0);
        drv1(1'b1, 8'h0B, 1'b0, 1'b0);
        v1 = 1'b1; d1 = 8'h77;
        rst = 1'b1;
        #1;
        q1.delete();
        q0.delete();
        check_all();
        @(negedge clk);
        tick();
        rst = 1'b0;
        drv1(1'b1, 8'h0C, 1'b1, 1'b0);
        drv1(1'b0, '0, 1'b1, 1'b0);
        drv1(1'b0, '0, 1'b1, 1'b0);
        v1 = 0; r1 = 0;

        // Single entry: combinational ready follows i_ready; replacement without bubble.
        drv0(1'b1, 8'h30, 1'b0, 1'b0);
        drv0(1'b1, 8'h31, 1'b0, 1'b0);
        drv0(1'b1, 8'h31, 1'b1, 1'b0);
        drv0(1'b1, 8'h32, 1'b1, 1'b0);
        drv0(1'b0, '0, 1'b1, 1'b1);
        drv0(1'b0, '0, 1'b1, 1'b0);

        // Random traffic on both instances.
        for (int n = 0; n < 10000; n++) begin
            v1 = ($urandom_range(0, 3) != 0);
            d1 = W'($urandom);
            r1 = ($urandom_range(0, 2) != 0);
            f1 = ($urandom_range(0, 24) == 0);
            v0 = ($urandom_range(0, 3) != 0);
            d0 = W'($urandom);
            r0 = ($urandom_range(0, 2) != 0);
            f0 = ($urandom_range(0, 24) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
